// File: rtl/dmem_lsu.sv
// dmem_lsu: data-side load/store unit, data RAM and MMIO page for the 5-stage core.
//
// Loads are combinational: o_rdata reflects state at the start of the cycle. Stores, FIFO
// push/pop, CYCLE load, overflow clear and fault capture all commit at the next rising edge.
//
// Ports:
//   i_clk         clock, all state updates on rising edge
//   i_reset       synchronous active-high reset
//   i_addr        byte address (M-stage ALU result)
//   i_wdata       store data
//   i_we / i_re   store / load request (both high behaves as a store)
//   i_memsize     RISC-V funct3 size code
//   o_rdata       extended load data, 0 when no non-faulting load
//   o_tx_data     console FIFO head byte (0 when empty)
//   o_tx_valid    console FIFO non-empty
//   i_tx_ready    consumer accepts head this cycle
//   o_fault       sticky access-fault flag
//   o_fault_addr  address of first faulting access since reset
//
// MMIO page: +0 TX (write pushes byte), +4 STAT, +8 CYCLE. Word access only.
module dmem_lsu #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [2:0]  i_memsize,
    output logic [31:0] o_rdata,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_fault,
    output logic [31:0] o_fault_addr
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_ram [MEM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [31:0]   r_cycle;
    logic          r_fault;
    logic [31:0]   r_fault_addr;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic          w_access;
    logic          w_size_ok;
    logic          w_aligned;
    logic          w_is_ram;
    logic          w_is_tx;
    logic          w_is_stat;
    logic          w_is_cyc;
    logic          w_mmio_ok;
    logic          w_fault;
    logic          w_store;
    logic          w_load;
    logic [AW-1:0] w_idx;

    always_comb begin
        w_access = i_we | i_re;

        // Store sizes: SB/SH/SW. Load sizes add LBU/LHU. Both high follows store rules.
        if (i_we) begin
            w_size_ok = !i_memsize[2] && (i_memsize[1:0] != 2'b11);
        end else begin
            w_size_ok = (i_memsize[1:0] != 2'b11) && !(i_memsize[2] && i_memsize[1]);
        end

        case (i_memsize[1:0])
            2'b01:   w_aligned = !i_addr[0];
            2'b10:   w_aligned = (i_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase

        w_is_ram  = (i_addr < RAM_BYTES);
        w_is_tx   = (i_addr == MMIO_BASE);
        w_is_stat = (i_addr == MMIO_BASE + 32'd4);
        w_is_cyc  = (i_addr == MMIO_BASE + 32'd8);
        w_mmio_ok = (w_is_tx || w_is_stat || w_is_cyc) && (i_memsize[1:0] == 2'b10);

        w_fault = w_access && !(w_size_ok && w_aligned && (w_is_ram || w_mmio_ok));
        w_store = i_we && !w_fault;
        // A load is only honoured when it is not being treated as a store that faulted.
        w_load  = i_re && !w_fault;
        w_idx   = i_addr[AW+1:2];
    end

    // ------------------------------------------------------------------
    // RAM write: byte enables and lane replication
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wlane;

    always_comb begin
        case (i_memsize[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wlane = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = i_wdata;
            end
        endcase
    end

    // No reset: RAM contents survive reset and a same-cycle RAM store still commits.
    always_ff @(posedge i_clk) begin
        if (w_store && w_is_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_ram[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] w_ram_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ram_ext;
    logic [31:0] w_stat;

    always_comb begin
        w_ram_word = r_ram[w_idx];

        case (i_addr[1:0])
            2'b00:   w_byte = w_ram_word[7:0];
            2'b01:   w_byte = w_ram_word[15:8];
            2'b10:   w_byte = w_ram_word[23:16];
            default: w_byte = w_ram_word[31:24];
        endcase
        w_half = i_addr[1] ? w_ram_word[31:16] : w_ram_word[15:0];

        case (i_memsize)
            3'b000:  w_ram_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ram_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ram_ext = {24'd0, w_byte};
            3'b101:  w_ram_ext = {16'd0, w_half};
            default: w_ram_ext = w_ram_word;
        endcase

        w_stat = {24'd0, 4'(r_count), 1'b0, r_ovf, (r_count == '0), (r_count == DEPTH_C)};

        o_rdata = 32'd0;
        if (w_load) begin
            if (w_is_ram) begin
                o_rdata = w_ram_ext;
            end else if (w_is_stat) begin
                o_rdata = w_stat;
            end else if (w_is_cyc) begin
                o_rdata = r_cycle;
            end
        end
    end

    // ------------------------------------------------------------------
    // Console TX FIFO
    // ------------------------------------------------------------------
    logic w_pop;
    logic w_push_req;
    logic w_push;

    always_comb begin
        w_pop      = (r_count != '0) && i_tx_ready;
        w_push_req = w_store && w_is_tx;
        // A full FIFO still accepts when the head leaves in the same cycle.
        w_push     = w_push_req && ((r_count != DEPTH_C) || w_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            r_fifo[r_tail] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_store && w_is_stat && i_wdata[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_tx_valid = (r_count != '0);
    assign o_tx_data  = o_tx_valid ? r_fifo[r_head] : 8'd0;

    // ------------------------------------------------------------------
    // CYCLE counter and fault capture
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle      <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else begin
            if (w_store && w_is_cyc) begin
                r_cycle <= i_wdata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_fault) begin
                r_fault <= 1'b1;
                if (!r_fault) begin
                    r_fault_addr <= i_addr;
                end
            end
        end
    end

    assign o_fault      = r_fault;
    assign o_fault_addr = r_fault_addr;

endmodule
